collatz_sweep_ctrl: RTL and testbench
=====================================

# collatz_sweep_ctrl

Sequencing controller for the Collatz step datapath. It accepts a command of the form (start seed, seed count) and drives the step unit through every seed in `start .. start+count-1`, one step per clock. For each seed it measures the orbit length to 1 and keeps the seed with the longest orbit. The result is returned over a valid/ready handshake, so a host-side I/O front end can queue sweeps instead of hand-feeding single seeds.

## Interface
- `BITS`, 64: iterator width in bits.
- `OLEN_BITS`, 16: orbit-length counter width; the step cap is `2^OLEN_BITS-1`.
- `CNT_BITS`, 16: width of the seed-count and seeds-done fields.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_start`  in  BITS  first seed.
- `cmd_count`  in  CNT_BITS  number of seeds to sweep.
- `abort`  in  1  stop the sweep and report partial results.
- `busy`  out  1  high in SEED, RUN and NEXT.
- `res_valid`  out  1  high in DONE.
- `res_ready`  in  1  result consumed.
- `res_best_seed`  out  BITS  seed with the longest orbit.
- `res_best_len`  out  OLEN_BITS  orbit length of `res_best_seed`.
- `res_seeds_done`  out  CNT_BITS  seeds fully processed, including excluded ones.
- `res_flags`  out  4  sticky flags: [0] overflow, [1] cap hit, [2] zero seed, [3] aborted.

## Operation
- **States:** IDLE, SEED, RUN, NEXT, DONE.
- **Reset values:**
  - State is IDLE.
  - All result registers are 0, including flags, best seed, best length and seeds done.
  - `res_valid` = 0, `busy` = 0, `cmd_ready` = 1.
- **IDLE:**
  - On `cmd_valid && cmd_ready`, latch the seed and the remaining count.
  - Clear the best seed, best length, seeds done and flags.
  - Go to SEED, or go straight to DONE if the count is 0.
- **SEED:**
  - Load `iter <= seed` and `len <= 0`.
  - If the seed is 0: set flag[2], increment seeds done, and go to NEXT with the seed marked excluded.
  - Otherwise go to RUN.
- **RUN** (one check per cycle, in this priority order):
  1. `iter==1`: go to NEXT.
  2. `len` at cap: set flag[1], mark the seed excluded, go to NEXT.
  3. Step overflows (`3*iter+1` does not fit in BITS): set flag[0], mark the seed excluded, go to NEXT.
  4. Otherwise: `iter <= step(iter)`, `len <= len+1`.
- **NEXT:**
  - Increment seeds done. A zero seed was already counted in SEED and is not counted again.
  - If the seed is not excluded and `len > best_len` (strictly greater), update the best seed and best length. Ties therefore keep the earlier seed.
  - Advance `seed <= seed+1`, wrapping modulo `2^BITS`. A wrapped seed of 0 is then handled by SEED as above.
  - Decrement the remaining count. Go to SEED if it is still nonzero, otherwise to DONE.
- **DONE:**
  - Hold `res_valid` and all result outputs stable until `res_ready` is seen.
  - On `res_valid && res_ready`, go to IDLE.
- **Abort:**
  - Sampled in SEED, RUN and NEXT. The next state is DONE and flag[3] is set.
  - The seed in flight is neither counted nor compared.
  - Abort is ignored in IDLE and DONE.
- **Width rule:** step arithmetic is computed at BITS+2 bits. Overflow means either of the top two bits is nonzero.
- A new command cannot be accepted while the result is unconsumed.

## Timing
- Command accepted at the end of cycle T gives SEED in T+1 and RUN in T+2.
- A seed with orbit length L occupies L+1 RUN cycles, then NEXT, i.e. L+3 cycles per seed.
- Single seed: `res_valid` rises in cycle T+4+L.
- `count==0`: `res_valid` rises in T+1.
- `cmd_ready` reasserts the cycle after the result handshake.
- Abort asserted in cycle A gives `res_valid` in A+1.
- `rst_n` low at any edge, including mid-sweep or while in DONE, returns all state to the reset values at that edge.

## Structure
- Shared package holds:
  - The state enum (IDLE/SEED/RUN/NEXT/DONE).
  - Flag bit index constants.
  - Default BITS, OLEN_BITS and CNT_BITS.
- Sub-module `collatz_step`: combinational. Takes `iter`, outputs `next` and `ovf`; `next` is `iter>>1` if even, `3*iter+1` if odd.
- The controller FSM, counters and best-tracking logic live in `collatz_sweep_ctrl`.

## Test plan
- **Single seed:** start=27, count=1. Expect best seed 27, best length 111, seeds done 1, flags 0, `res_valid` at T+115.
- **Range:** start=1, count=10. Expect best seed 9, best length 19, seeds done 10. Seed 1 has length 0.
- **Cap and zero:**
  - `OLEN_BITS=6`, start=27, count=1: flag[1]=1, best length 0, seeds done 1.
  - start=0, count=1: flag[2]=1, seeds done 1.
- **Overflow and wrap:** `BITS=8`, start=255, count=2. Expect flag[0]=1 (255 overflows), then the wrapped seed 0 sets flag[2]; seeds done 2.
- **Abort:** start=27, count=5, abort pulsed 50 cycles after accept. Expect `res_valid` the next cycle, flag[3]=1, seeds done 0.
- **Backpressure and reset:**
  - Hold `res_ready` low for 20 cycles: outputs stable and `cmd_ready` low; handshake then gives IDLE.
  - `rst_n` low mid-RUN: all outputs return to the reset values.

Source files
------------

// File: rtl/collatz_sweep_ctrl_pkg.sv
// Shared types and constants for the Collatz sweep controller.
// Holds the FSM state enum, result flag bit positions and default widths.
package collatz_sweep_ctrl_pkg;

  localparam int unsigned DefBits     = 64;
  localparam int unsigned DefOlenBits = 16;
  localparam int unsigned DefCntBits  = 16;

  localparam int unsigned NumFlags  = 4;
  localparam int unsigned FlagOvf   = 0;
  localparam int unsigned FlagCap   = 1;
  localparam int unsigned FlagZero  = 2;
  localparam int unsigned FlagAbort = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StRun,
    StNext,
    StDone
  } state_e;

endpackage

// File: rtl/collatz_sweep_ctrl_if.sv
// Command/result bundle between a host front end and the sweep controller.
// The host uses the master modport; the controller uses the slave modport.
interface collatz_sweep_ctrl_if
  import collatz_sweep_ctrl_pkg::*;
#(
  parameter int unsigned BITS      = DefBits,
  parameter int unsigned OLEN_BITS = DefOlenBits,
  parameter int unsigned CNT_BITS  = DefCntBits
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [BITS-1:0]      cmd_start;
  logic [CNT_BITS-1:0]  cmd_count;
  logic                 abort;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [BITS-1:0]      res_best_seed;
  logic [OLEN_BITS-1:0] res_best_len;
  logic [CNT_BITS-1:0]  res_seeds_done;
  logic [NumFlags-1:0]  res_flags;

  modport master (
    output cmd_valid, cmd_start, cmd_count, abort, res_ready,
    input  cmd_ready, busy, res_valid, res_best_seed, res_best_len, res_seeds_done, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_count, abort, res_ready,
    output cmd_ready, busy, res_valid, res_best_seed, res_best_len, res_seeds_done, res_flags
  );

endinterface

// File: rtl/collatz_step.sv
// Combinational Collatz step: halve even values, 3x+1 odd values.
// The odd path is evaluated two bits wider so overflow shows up in the top bits.
module collatz_step
  import collatz_sweep_ctrl_pkg::*;
#(
  parameter int unsigned BITS = DefBits
) (
  input  logic [BITS-1:0] iter,
  output logic [BITS-1:0] next,
  output logic            ovf
);

  localparam int unsigned WideBits = BITS + 2;

  logic [WideBits-1:0] wide;

  always_comb begin
    wide = ({2'b00, iter} << 1) + {2'b00, iter} + WideBits'(1);
    next = iter >> 1;
    ovf  = 1'b0;
    if (iter[0]) begin
      next = wide[BITS-1:0];
      ovf  = |wide[WideBits-1:BITS];
    end
  end

endmodule

// File: rtl/collatz_sweep_ctrl.sv
// Sweeps a range of seeds through the Collatz step unit, one step per clock,
// and reports the seed with the longest orbit to 1 over a valid/ready handshake.
module collatz_sweep_ctrl
  import collatz_sweep_ctrl_pkg::*;
#(
  parameter int unsigned BITS      = DefBits,
  parameter int unsigned OLEN_BITS = DefOlenBits,
  parameter int unsigned CNT_BITS  = DefCntBits
) (
  input logic                 clk,
  input logic                 rst_n,
  collatz_sweep_ctrl_if.slave bus
);

  localparam logic [OLEN_BITS-1:0] LenCap = '1;

  state_e               state_q, state_d;
  logic [BITS-1:0]      seed_q, seed_d;
  logic [BITS-1:0]      iter_q, iter_d;
  logic [BITS-1:0]      best_seed_q, best_seed_d;
  logic [OLEN_BITS-1:0] len_q, len_d;
  logic [OLEN_BITS-1:0] best_len_q, best_len_d;
  logic [CNT_BITS-1:0]  remain_q, remain_d;
  logic [CNT_BITS-1:0]  done_q, done_d;
  logic [NumFlags-1:0]  flags_q, flags_d;
  logic                 excl_q, excl_d;
  logic                 zero_q, zero_d;

  logic [BITS-1:0] step_next;
  logic            step_ovf;

  collatz_step #(
    .BITS(BITS)
  ) u_step (
    .iter(iter_q),
    .next(step_next),
    .ovf (step_ovf)
  );

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    iter_d      = iter_q;
    best_seed_d = best_seed_q;
    len_d       = len_q;
    best_len_d  = best_len_q;
    remain_d    = remain_q;
    done_d      = done_q;
    flags_d     = flags_q;
    excl_d      = excl_q;
    zero_d      = zero_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          seed_d      = bus.cmd_start;
          remain_d    = bus.cmd_count;
          best_seed_d = '0;
          best_len_d  = '0;
          done_d      = '0;
          flags_d     = '0;
          state_d     = (bus.cmd_count == '0) ? StDone : StSeed;
        end
      end

      StSeed: begin
        iter_d = seed_q;
        len_d  = '0;
        excl_d = (seed_q == '0);
        zero_d = (seed_q == '0);
        // Abort wins over everything else in the cycle it is sampled.
        if (bus.abort) begin
          flags_d[FlagAbort] = 1'b1;
          state_d            = StDone;
        end else if (seed_q == '0) begin
          flags_d[FlagZero] = 1'b1;
          done_d            = done_q + CNT_BITS'(1);
          state_d           = StNext;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (bus.abort) begin
          flags_d[FlagAbort] = 1'b1;
          state_d            = StDone;
        end else if (iter_q == BITS'(1)) begin
          state_d = StNext;
        end else if (len_q == LenCap) begin
          flags_d[FlagCap] = 1'b1;
          excl_d           = 1'b1;
          state_d          = StNext;
        end else if (step_ovf) begin
          flags_d[FlagOvf] = 1'b1;
          excl_d           = 1'b1;
          state_d          = StNext;
        end else begin
          iter_d = step_next;
          len_d  = len_q + OLEN_BITS'(1);
        end
      end

      StNext: begin
        if (bus.abort) begin
          flags_d[FlagAbort] = 1'b1;
          state_d            = StDone;
        end else begin
          // Zero seeds were already counted when they were loaded.
          if (!zero_q) begin
            done_d = done_q + CNT_BITS'(1);
          end
          if (!excl_q && (len_q > best_len_q)) begin
            best_seed_d = seed_q;
            best_len_d  = len_q;
          end
          seed_d   = seed_q + BITS'(1);
          remain_d = remain_q - CNT_BITS'(1);
          state_d  = (remain_q == CNT_BITS'(1)) ? StDone : StSeed;
        end
      end

      StDone: begin
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      seed_q      <= '0;
      iter_q      <= '0;
      best_seed_q <= '0;
      len_q       <= '0;
      best_len_q  <= '0;
      remain_q    <= '0;
      done_q      <= '0;
      flags_q     <= '0;
      excl_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      iter_q      <= iter_d;
      best_seed_q <= best_seed_d;
      len_q       <= len_d;
      best_len_q  <= best_len_d;
      remain_q    <= remain_d;
      done_q      <= done_d;
      flags_q     <= flags_d;
      excl_q      <= excl_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.cmd_ready      = (state_q == StIdle);
  assign bus.busy           = (state_q == StSeed) || (state_q == StRun) || (state_q == StNext);
  assign bus.res_valid      = (state_q == StDone);
  assign bus.res_best_seed  = best_seed_q;
  assign bus.res_best_len   = best_len_q;
  assign bus.res_seeds_done = done_q;
  assign bus.res_flags      = flags_q;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Self-checking bench: a seed-level schedule model predicts every cycle of the
// default-width controller; narrow and low-cap instances get literal checks.
module tb_collatz_sweep_ctrl;
  import collatz_sweep_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  collatz_sweep_ctrl_if #(.BITS(64), .OLEN_BITS(16), .CNT_BITS(16)) m_if ();
  collatz_sweep_ctrl_if #(.BITS(64), .OLEN_BITS(6),  .CNT_BITS(16)) c_if ();
  collatz_sweep_ctrl_if #(.BITS(8),  .OLEN_BITS(16), .CNT_BITS(16)) n_if ();

  collatz_sweep_ctrl #(.BITS(64), .OLEN_BITS(16), .CNT_BITS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if)
  );
  collatz_sweep_ctrl #(.BITS(64), .OLEN_BITS(6), .CNT_BITS(16)) u_cap (
    .clk(clk), .rst_n(rst_n), .bus(c_if)
  );
  collatz_sweep_ctrl #(.BITS(8), .OLEN_BITS(16), .CNT_BITS(16)) u_nar (
    .clk(clk), .rst_n(rst_n), .bus(n_if)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (seed-level, default widths) ----------------
  localparam int MaxSeeds = 32;
  localparam int Cap      = 65535;

  int          s_kind  [MaxSeeds];  // 0 reached 1, 1 cap, 2 overflow, 3 zero seed
  int          s_len   [MaxSeeds];
  int          s_first [MaxSeeds];
  int          s_last  [MaxSeeds];
  logic [63:0] s_seed  [MaxSeeds];
  int          sched_n = 0;
  int          done_k  = 0;
  int          k       = 0;
  int          phase   = 0;  // 0 idle, 1 sweeping, 2 result pending
  logic [63:0] exp_seed = '0;
  logic [63:0] exp_len  = '0;
  logic [63:0] exp_done = '0;
  logic [3:0]  exp_flags = '0;

  function automatic void orbit(input logic [63:0] s, output int kind, output int len);
    logic [65:0] it, nx;
    kind = 3;
    len  = 0;
    if (s == 64'd0) return;
    it = {2'b00, s};
    for (int l = 0; l <= Cap; l++) begin
      len = l;
      if (it == 66'd1) begin kind = 0; return; end
      if (l == Cap) begin kind = 1; return; end
      nx = it * 3 + 1;
      if (it[0] && nx >= 66'h1_0000_0000_0000_0000) begin kind = 2; return; end
      it = it[0] ? nx : it / 2;
    end
  endfunction

  // Cycle 1 is the first cycle after acceptance; each seed ends with its NEXT cycle.
  function automatic void build(input logic [63:0] st, input int cnt);
    int kd, ln, kk;
    kk      = 1;
    sched_n = (cnt < MaxSeeds) ? cnt : MaxSeeds;
    for (int i = 0; i < sched_n; i++) begin
      s_seed[i] = st + 64'(i);
      orbit(s_seed[i], kd, ln);
      s_kind[i]  = kd;
      s_len[i]   = ln;
      s_first[i] = kk;
      s_last[i]  = (kd == 3) ? kk + 1 : kk + ln + 2;
      kk         = s_last[i] + 1;
    end
    done_k = kk;
  endfunction

  // Results from every per-seed event that happened strictly before cycle lim.
  function automatic void results(input int lim, input bit ab);
    int bl;
    bl        = 0;
    exp_seed  = '0;
    exp_done  = '0;
    exp_flags = '0;
    for (int i = 0; i < sched_n; i++) begin
      if (s_kind[i] == 3) begin
        if (s_first[i] < lim) begin exp_flags[2] = 1'b1; exp_done++; end
      end else if (s_kind[i] != 0) begin
        if (s_last[i] - 1 < lim) exp_flags[(s_kind[i] == 1) ? 1 : 0] = 1'b1;
        if (s_last[i] < lim) exp_done++;
      end else if (s_last[i] < lim) begin
        exp_done++;
        if (s_len[i] > bl) begin bl = s_len[i]; exp_seed = s_seed[i]; end
      end
    end
    exp_len      = 64'(bl);
    exp_flags[3] = ab;
  endfunction

  always @(negedge clk) begin
    chk("cmd_ready", 64'(m_if.cmd_ready), 64'(phase == 0));
    chk("busy", 64'(m_if.busy), 64'(phase == 1));
    chk("res_valid", 64'(m_if.res_valid), 64'(phase == 2));
    if (phase == 2) begin
      chk("best_seed", m_if.res_best_seed, exp_seed);
      chk("best_len", 64'(m_if.res_best_len), exp_len);
      chk("seeds_done", 64'(m_if.res_seeds_done), exp_done);
      chk("flags", 64'(m_if.res_flags), 64'(exp_flags));
    end
    if (!rst_n) begin
      phase = 0;
    end else begin
      case (phase)
        0: if (m_if.cmd_valid) begin
          build(m_if.cmd_start, int'(m_if.cmd_count));
          if (done_k == 1) begin results(1, 1'b0); phase = 2; end
          else begin k = 1; phase = 1; end
        end
        1: if (m_if.abort) begin results(k, 1'b1); phase = 2; end
           else if (k + 1 == done_k) begin results(done_k, 1'b0); phase = 2; end
           else k++;
        default: if (m_if.res_ready) phase = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_sim();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 64'(m_if.cmd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(m_if.busy), 64'd0);
    chk({tag, "_res_valid"}, 64'(m_if.res_valid), 64'd0);
    chk({tag, "_best_seed"}, m_if.res_best_seed, 64'd0);
    chk({tag, "_best_len"}, 64'(m_if.res_best_len), 64'd0);
    chk({tag, "_seeds_done"}, 64'(m_if.res_seeds_done), 64'd0);
    chk({tag, "_flags"}, 64'(m_if.res_flags), 64'd0);
  endtask

  // lat = cycles from acceptance until res_valid is seen (1 = first cycle after).
  task automatic issue(input logic [63:0] st, input logic [15:0] cnt, input int ab_at,
                       output int lat);
    m_if.cmd_valid = 1'b1;
    m_if.cmd_start = st;
    m_if.cmd_count = cnt;
    tick();
    m_if.cmd_valid = 1'b0;
    lat = 1;
    while (m_if.res_valid !== 1'b1 && lat < 40000) begin
      if (lat == ab_at) m_if.abort = 1'b1;
      tick();
      m_if.abort = 1'b0;
      lat++;
    end
    if (m_if.res_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: res_valid never rose for start %0h count %0d", st, cnt);
      finish_sim();
    end
  endtask

  task automatic consume(input int hold);
    repeat (hold) tick();
    m_if.res_ready = 1'b1;
    tick();
    m_if.res_ready = 1'b0;
    chk("ready_after_handshake", 64'(m_if.cmd_ready), 64'd1);
  endtask

  initial begin
    int lat, kd, ln, lc, lnr, n, sel, cnt, ab;
    logic [63:0] st;
    m_if.cmd_valid = 1'b0; m_if.cmd_start = '0; m_if.cmd_count = '0;
    m_if.abort = 1'b0; m_if.res_ready = 1'b0;
    c_if.cmd_valid = 1'b0; c_if.cmd_start = '0; c_if.cmd_count = '0;
    c_if.abort = 1'b0; c_if.res_ready = 1'b0;
    n_if.cmd_valid = 1'b0; n_if.cmd_start = '0; n_if.cmd_count = '0;
    n_if.abort = 1'b0; n_if.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset("por");

    // Pin the model against hand-known orbit facts.
    orbit(64'd27, kd, ln);
    chk("model_len27", 64'(ln), 64'd111);
    orbit(64'd9, kd, ln);
    chk("model_len9", 64'(ln), 64'd19);
    orbit(64'hFFFF_FFFF_FFFF_FFFF, kd, ln);
    chk("model_ovf_kind", 64'(kd), 64'd2);

    issue(64'd27, 16'd1, 0, lat);
    chk("single_lat", 64'(lat), 64'd115);
    chk("single_seed", m_if.res_best_seed, 64'd27);
    chk("single_len", 64'(m_if.res_best_len), 64'd111);
    chk("single_done", 64'(m_if.res_seeds_done), 64'd1);
    chk("single_flags", 64'(m_if.res_flags), 64'd0);
    consume(0);

    issue(64'd1, 16'd10, 0, lat);
    chk("range_seed", m_if.res_best_seed, 64'd9);
    chk("range_len", 64'(m_if.res_best_len), 64'd19);
    chk("range_done", 64'(m_if.res_seeds_done), 64'd10);
    consume(1);

    issue(64'd0, 16'd1, 0, lat);
    chk("zero_lat", 64'(lat), 64'd3);
    chk("zero_flags", 64'(m_if.res_flags), 64'h4);
    chk("zero_done", 64'(m_if.res_seeds_done), 64'd1);
    consume(0);

    issue(64'd5, 16'd0, 0, lat);
    chk("count0_lat", 64'(lat), 64'd1);
    consume(0);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 0, lat);
    chk("wrap_lat", 64'(lat), 64'd6);
    chk("wrap_flags", 64'(m_if.res_flags), 64'h5);
    chk("wrap_done", 64'(m_if.res_seeds_done), 64'd2);
    consume(0);

    issue(64'd27, 16'd5, 50, lat);
    chk("abort_lat", 64'(lat), 64'd51);
    chk("abort_flags", 64'(m_if.res_flags), 64'h8);
    chk("abort_done", 64'(m_if.res_seeds_done), 64'd0);
    consume(2);

    // Backpressure with a competing command that must not be taken.
    issue(64'd7, 16'd3, 0, lat);
    m_if.cmd_valid = 1'b1; m_if.cmd_start = 64'd100; m_if.cmd_count = 16'd1;
    repeat (20) tick();
    m_if.cmd_valid = 1'b0;
    chk("bp_cmd_ready", 64'(m_if.cmd_ready), 64'd0);
    chk("bp_valid", 64'(m_if.res_valid), 64'd1);
    chk("bp_seed", m_if.res_best_seed, 64'd9);
    consume(0);

    m_if.cmd_valid = 1'b1; m_if.cmd_start = 64'd27; m_if.cmd_count = 16'd3;
    tick();
    m_if.cmd_valid = 1'b0;
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("midrun");

    // Low step cap and 8-bit iterator instances.
    c_if.cmd_start = 64'd27; c_if.cmd_count = 16'd1; c_if.cmd_valid = 1'b1;
    n_if.cmd_start = 8'd255; n_if.cmd_count = 16'd2; n_if.cmd_valid = 1'b1;
    tick();
    c_if.cmd_valid = 1'b0; n_if.cmd_valid = 1'b0;
    lc = 0; lnr = 0; n = 1;
    while ((lc == 0 || lnr == 0) && n < 200) begin
      if (c_if.res_valid && lc == 0) lc = n;
      if (n_if.res_valid && lnr == 0) lnr = n;
      if (lc == 0 || lnr == 0) begin tick(); n++; end
    end
    chk("cap_lat", 64'(lc), 64'd67);
    chk("cap_flags", 64'(c_if.res_flags), 64'h2);
    chk("cap_len", 64'(c_if.res_best_len), 64'd0);
    chk("cap_done", 64'(c_if.res_seeds_done), 64'd1);
    chk("ovf8_lat", 64'(lnr), 64'd6);
    chk("ovf8_flags", 64'(n_if.res_flags), 64'h5);
    chk("ovf8_done", 64'(n_if.res_seeds_done), 64'd2);
    c_if.res_ready = 1'b1; n_if.res_ready = 1'b1;
    tick();
    c_if.res_ready = 1'b0; n_if.res_ready = 1'b0;
    chk("cap_ready_back", 64'(c_if.cmd_ready), 64'd1);

    n_if.cmd_start = 8'd84; n_if.cmd_count = 16'd2; n_if.cmd_valid = 1'b1;
    tick();
    n_if.cmd_valid = 1'b0;
    n = 1;
    while (!n_if.res_valid && n < 200) begin tick(); n++; end
    chk("nar_lat", 64'(n), 64'd16);
    chk("nar_seed", 64'(n_if.res_best_seed), 64'd84);
    chk("nar_len", 64'(n_if.res_best_len), 64'd9);
    chk("nar_flags", 64'(n_if.res_flags), 64'h1);
    n_if.res_ready = 1'b1;
    tick();
    n_if.res_ready = 1'b0;

    for (int t = 0; t < 20; t++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       st = 64'($urandom_range(0, 3000));
        1:       st = {$urandom, $urandom};
        2:       st = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
        default: st = 64'($urandom);
      endcase
      cnt = (sel == 0 || sel == 2) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 2));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 200)) : 0;
      issue(st, 16'(cnt), ab, lat);
      consume(int'($urandom_range(0, 3)));
    end

    finish_sim();
  end

endmodule
